rat_path_player: RTL and testbench

Downstream of the maze-solving controller. Collects the 2-bit direction codes the controller releases from its path stack during its output phase, stores them in an internal FIFO, then replays them as a stream of absolute (x, y) maze coordinates. The first coordinate is the start cell (0,0), and the last is the goal. Each coordinate goes out over a valid/ready handshake, with move counting and out-of-bounds/overflow detection.

---
 rtl/rat_path_player.sv | 137 +++++++++++++
 tb/tb_rat_path_player.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_path_player.sv
// rtl/rat_path_player.sv - buffers maze path direction codes and replays them as (x, y) coordinates
module rat_path_player #(
    parameter int DEPTH = 256,
    parameter int CW    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               dir_in,
    input  logic                     dir_valid,
    input  logic                     path_end,
    output logic                     dir_ready,
    output logic [CW-1:0]            pos_x,
    output logic [CW-1:0]            pos_y,
    output logic                     pos_valid,
    input  logic                     pos_ready,
    output logic [$clog2(DEPTH):0]   move_count,
    output logic                     busy,
    output logic                     path_done,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE   = 1;
    localparam logic [CW-1:0] COORD_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_EMIT, S_DONE, S_ERR} state_t;

    state_t        state_q, state_d;
    logic [1:0]    mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] nx, ny;
    logic [1:0]    head;
    logic          full, empty, push, oob;

    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = (wr_q == rd_q);
    assign head  = mem_q[rd_q[AW-1:0]];
    assign push  = !start && (state_q == S_FILL) && dir_valid && !full;

    // Candidate next position from the FIFO head; a move that would wrap flags oob instead.
    always_comb begin
        nx  = x_q;
        ny  = y_q;
        oob = 1'b0;
        case (head)
            2'b00:   if (x_q == '1) oob = 1'b1; else nx = x_q + COORD_ONE;
            2'b11:   if (x_q == '0) oob = 1'b1; else nx = x_q - COORD_ONE;
            2'b01:   if (y_q == '1) oob = 1'b1; else ny = y_q + COORD_ONE;
            default: if (y_q == '0) oob = 1'b1; else ny = y_q - COORD_ONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        if (start) begin
            state_d = S_FILL;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (dir_valid && full) begin
                        state_d = S_ERR;
                    end else begin
                        if (dir_valid) begin
                            wr_d  = wr_q + PTR_ONE;
                            cnt_d = cnt_q + PTR_ONE;
                        end
                        if (path_end) begin
                            state_d = S_EMIT;
                            cnt_d   = '0;
                            x_d     = '0;
                            y_d     = '0;
                        end
                    end
                end
                S_EMIT: begin
                    if (pos_ready) begin
                        if (empty) begin
                            state_d = S_DONE;
                        end else if (oob) begin
                            state_d = S_ERR;
                        end else begin
                            rd_d  = rd_q + PTR_ONE;
                            cnt_d = cnt_q + PTR_ONE;
                            x_d   = nx;
                            y_d   = ny;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= dir_in;
        end
    end

    assign dir_ready  = (state_q == S_FILL) && !full;
    assign pos_valid  = (state_q == S_EMIT);
    assign pos_x      = x_q;
    assign pos_y      = y_q;
    assign move_count = cnt_q;
    assign busy       = (state_q == S_FILL) || (state_q == S_EMIT);
    assign path_done  = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
endmodule

// File: tb/tb_rat_path_player.sv
// tb/tb_rat_path_player.sv - directed self-checking bench for rat_path_player
module tb_rat_path_player;
    localparam int DEPTH = 256;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst, start, dir_valid, path_end, pos_ready;
    logic [1:0]    dir_in;
    logic          dir_ready, pos_valid, busy, path_done, err;
    logic [CW-1:0] pos_x, pos_y;
    logic [8:0]    move_count;

    int checks = 0;
    int errors = 0;
    int ex[$];
    int ey[$];

    rat_path_player #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .dir_valid(dir_valid),
        .path_end(path_end), .dir_ready(dir_ready), .pos_x(pos_x), .pos_y(pos_y),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .move_count(move_count),
        .busy(busy), .path_done(path_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_dir(input logic [1:0] d);
        dir_in    = d;
        dir_valid = 1'b1;
        tick();
        dir_valid = 1'b0;
    endtask

    task automatic do_end();
        path_end = 1'b1;
        tick();
        path_end = 1'b0;
    endtask

    task automatic replay(input int mode, input string name);
        int gx[$];
        int gy[$];
        int cyc = 0;
        int phase = 0;
        logic held = 1'b0;
        int hx = 0;
        int hy = 0;
        while (!path_done && !err && cyc < 400) begin
            pos_ready = (mode == 0) ? 1'b1 : (phase % 3 == 0);
            if (pos_valid) begin
                if (held) begin
                    checks++;
                    if (int'(pos_x) !== hx || int'(pos_y) !== hy) begin
                        errors++;
                        $display("FAIL %s_hold: got (%0d,%0d) expected (%0d,%0d)", name, pos_x, pos_y, hx, hy);
                    end
                end
                if (pos_ready) begin
                    gx.push_back(int'(pos_x));
                    gy.push_back(int'(pos_y));
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hx = int'(pos_x);
                    hy = int'(pos_y);
                end
            end
            phase++;
            tick();
            cyc++;
        end
        pos_ready = 1'b0;
        checks++;
        if (cyc >= 400) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles expected fewer than 400", name, cyc);
        end
        checks++;
        if (gx.size() !== ex.size()) begin
            errors++;
            $display("FAIL %s_beats: got %0d expected %0d", name, gx.size(), ex.size());
        end
        for (int i = 0; i < gx.size() && i < ex.size(); i++) begin
            checks++;
            if (gx[i] !== ex[i] || gy[i] !== ey[i]) begin
                errors++;
                $display("FAIL %s_beat%0d: got (%0d,%0d) expected (%0d,%0d)", name, i, gx[i], gy[i], ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if ({dir_ready, pos_valid, busy, path_done, err} !== 5'b0 || pos_x !== 4'd0 || pos_y !== 4'd0 || move_count !== 9'd0) begin
            errors++;
            $display("FAIL reset: got rdy=%0b val=%0b busy=%0b done=%0b err=%0b x=%0d y=%0d cnt=%0d expected all 0",
                     dir_ready, pos_valid, busy, path_done, err, pos_x, pos_y, move_count);
        end
    endtask

    task automatic load_basic();
        do_start();
        checks++;
        if (dir_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_fill: got rdy=%0b busy=%0b expected 1 1", dir_ready, busy);
        end
        push_dir(2'b00);
        checks++;
        if (move_count !== 9'd1) begin
            errors++;
            $display("FAIL push_count: got %0d expected 1", move_count);
        end
        push_dir(2'b00);
        push_dir(2'b01);
        push_dir(2'b01);
        push_dir(2'b00);
        do_end();
        ex = '{0, 1, 2, 2, 2, 3};
        ey = '{0, 0, 0, 1, 2, 2};
    endtask

    task automatic test_basic();
        load_basic();
        checks++;
        if (pos_valid !== 1'b1 || move_count !== 9'd0) begin
            errors++;
            $display("FAIL basic_first: got val=%0b cnt=%0d expected 1 0", pos_valid, move_count);
        end
        replay(0, "basic");
        checks++;
        if (path_done !== 1'b1 || move_count !== 9'd5 || pos_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%0b cnt=%0d val=%0b expected 1 5 0", path_done, move_count, pos_valid);
        end
    endtask

    task automatic test_backpressure();
        load_basic();
        replay(1, "bp");
        checks++;
        if (path_done !== 1'b1 || move_count !== 9'd5) begin
            errors++;
            $display("FAIL bp_done: got done=%0b cnt=%0d expected 1 5", path_done, move_count);
        end
    endtask

    task automatic test_empty();
        do_start();
        do_end();
        ex = '{0};
        ey = '{0};
        replay(0, "empty");
        checks++;
        if (path_done !== 1'b1 || move_count !== 9'd0) begin
            errors++;
            $display("FAIL empty_done: got done=%0b cnt=%0d expected 1 0", path_done, move_count);
        end
    endtask

    task automatic test_bound_left();
        do_start();
        push_dir(2'b11);
        do_end();
        ex = '{0};
        ey = '{0};
        replay(0, "left");
        checks++;
        if (err !== 1'b1 || pos_valid !== 1'b0 || path_done !== 1'b0) begin
            errors++;
            $display("FAIL left_err: got err=%0b val=%0b done=%0b expected 1 0 0", err, pos_valid, path_done);
        end
    endtask

    task automatic test_bound_right();
        do_start();
        repeat (16) push_dir(2'b00);
        do_end();
        ex = {};
        ey = {};
        for (int i = 0; i < 16; i++) begin
            ex.push_back(i);
            ey.push_back(0);
        end
        replay(0, "right");
        checks++;
        if (err !== 1'b1 || pos_valid !== 1'b0 || pos_x !== 4'd15 || move_count !== 9'd15) begin
            errors++;
            $display("FAIL right_err: got err=%0b val=%0b x=%0d cnt=%0d expected 1 0 15 15", err, pos_valid, pos_x, move_count);
        end
    endtask

    task automatic test_overflow_restart();
        do_start();
        repeat (DEPTH) push_dir(2'b01);
        checks++;
        if (dir_ready !== 1'b0 || move_count !== 9'd256 || err !== 1'b0) begin
            errors++;
            $display("FAIL full: got rdy=%0b cnt=%0d err=%0b expected 0 256 0", dir_ready, move_count, err);
        end
        push_dir(2'b00);
        checks++;
        if (err !== 1'b1 || dir_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow: got err=%0b rdy=%0b busy=%0b expected 1 0 0", err, dir_ready, busy);
        end
        repeat (3) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %0b expected 1", err);
        end
        do_start();
        checks++;
        if (err !== 1'b0 || move_count !== 9'd0 || dir_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: got err=%0b cnt=%0d rdy=%0b busy=%0b expected 0 0 1 1", err, move_count, dir_ready, busy);
        end
        push_dir(2'b01);
        push_dir(2'b00);
        do_end();
        ex = '{0, 0, 1};
        ey = '{0, 1, 1};
        replay(0, "restart");
        checks++;
        if (path_done !== 1'b1 || move_count !== 9'd2) begin
            errors++;
            $display("FAIL restart_done: got done=%0b cnt=%0d expected 1 2", path_done, move_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dir_in = 2'b00;
        dir_valid = 1'b0;
        path_end = 1'b0;
        pos_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_bound_left();
        test_bound_right();
        test_overflow_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
